// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and EX forwarding
module id_ex_stage #(
   parameter int DW  = 32,
   parameter int CW  = 12,
   parameter int BCW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           id_valid,
   input  logic [31:0]    id_pc,
   input  logic [4:0]     id_rs1,
   input  logic [4:0]     id_rs2,
   input  logic [4:0]     id_rd,
   input  logic [DW-1:0]  id_rd1,
   input  logic [DW-1:0]  id_rd2,
   input  logic [DW-1:0]  id_imm,
   input  logic           id_regwrite,
   input  logic           id_memread,
   input  logic [CW-1:0]  id_ctrl,
   input  logic           flush,
   input  logic           mem_regwrite,
   input  logic [4:0]     mem_rd,
   input  logic [DW-1:0]  mem_result,
   input  logic           wb_regwrite,
   input  logic [4:0]     wb_rd,
   input  logic [DW-1:0]  wb_result,
   output logic           stall,
   output logic           ex_valid,
   output logic [31:0]    ex_pc,
   output logic [4:0]     ex_rs1,
   output logic [4:0]     ex_rs2,
   output logic [4:0]     ex_rd,
   output logic [DW-1:0]  ex_imm,
   output logic           ex_regwrite,
   output logic           ex_memread,
   output logic [CW-1:0]  ex_ctrl,
   output logic [DW-1:0]  ex_a,
   output logic [DW-1:0]  ex_b,
   output logic [1:0]     fwd_a,
   output logic [1:0]     fwd_b,
   output logic [BCW-1:0] bubble_cnt
);

   logic [DW-1:0] ex_rd1;
   logic [DW-1:0] ex_rd2;
   logic          hz;

   // rs2 is compared even for instructions that ignore it; a spare bubble is harmless
   assign hz = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   assign stall = hz & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_ctrl     <= '0;
         bubble_cnt  <= '0;
      end else if (flush || hz) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_ctrl     <= '0;
         // only load-use bubbles are counted; flush bubbles are not
         if (!flush && bubble_cnt != {BCW{1'b1}})
            bubble_cnt <= bubble_cnt + {{(BCW-1){1'b0}}, 1'b1};
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_rd1      <= id_rd1;
         ex_rd2      <= id_rd2;
         ex_imm      <= id_imm;
         ex_regwrite <= id_regwrite & id_valid;
         ex_memread  <= id_memread & id_valid;
         ex_ctrl     <= id_ctrl;
      end
   end

   // MEM is the younger producer, so it wins over WB
   always_comb begin
      fwd_a = 2'd0;
      ex_a  = ex_rd1;
      if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1) begin
         fwd_a = 2'd2;
         ex_a  = mem_result;
      end else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1) begin
         fwd_a = 2'd1;
         ex_a  = wb_result;
      end
   end

   always_comb begin
      fwd_b = 2'd0;
      ex_b  = ex_rd2;
      if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2) begin
         fwd_b = 2'd2;
         ex_b  = mem_result;
      end else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2) begin
         fwd_b = 2'd1;
         ex_b  = wb_result;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;

   localparam int DW  = 32;
   localparam int CW  = 12;
   localparam int BCW = 4;

   logic           clk, rst;
   logic           id_valid, id_regwrite, id_memread, flush;
   logic [31:0]    id_pc;
   logic [4:0]     id_rs1, id_rs2, id_rd;
   logic [DW-1:0]  id_rd1, id_rd2, id_imm;
   logic [CW-1:0]  id_ctrl;
   logic           mem_regwrite, wb_regwrite;
   logic [4:0]     mem_rd, wb_rd;
   logic [DW-1:0]  mem_result, wb_result;
   logic           stall, ex_valid, ex_regwrite, ex_memread;
   logic [31:0]    ex_pc;
   logic [4:0]     ex_rs1, ex_rs2, ex_rd;
   logic [DW-1:0]  ex_imm, ex_a, ex_b;
   logic [CW-1:0]  ex_ctrl;
   logic [1:0]     fwd_a, fwd_b;
   logic [BCW-1:0] bubble_cnt;

   id_ex_stage #(.DW(DW), .CW(CW), .BCW(BCW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
      .flush(flush), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
      .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .bubble_cnt(bubble_cnt)
   );

   typedef enum int {
      S_EXV, S_PC, S_RS1, S_RS2, S_RD, S_IMM, S_RW, S_MR, S_CTRL,
      S_A, S_B, S_FA, S_FB, S_BUB, S_STALL
   } sel_t;

   typedef struct {
      string       tag;
      sel_t        sel;
      logic [63:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_bub = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] observe(sel_t s);
      case (s)
         S_EXV:   return 64'(ex_valid);
         S_PC:    return 64'(ex_pc);
         S_RS1:   return 64'(ex_rs1);
         S_RS2:   return 64'(ex_rs2);
         S_RD:    return 64'(ex_rd);
         S_IMM:   return 64'(ex_imm);
         S_RW:    return 64'(ex_regwrite);
         S_MR:    return 64'(ex_memread);
         S_CTRL:  return 64'(ex_ctrl);
         S_A:     return 64'(ex_a);
         S_B:     return 64'(ex_b);
         S_FA:    return 64'(fwd_a);
         S_FB:    return 64'(fwd_b);
         S_BUB:   return 64'(bubble_cnt);
         default: return 64'(stall);
      endcase
   endfunction

   task automatic push(input string tag, input sel_t sel, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [63:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_cmp++;
         assert (obs === e.exp)
         else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic settle();
      #1;
      check_all();
   endtask

   task automatic idle();
      id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_regwrite = 0; id_memread = 0;
      id_ctrl = 0; flush = 0; mem_regwrite = 0; mem_rd = 0; mem_result = 0;
      wb_regwrite = 0; wb_rd = 0; wb_result = 0;
   endtask

   task automatic drive_lw(input logic [4:0] rd);
      idle();
      id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = rd; id_rs1 = 5'd1;
      id_ctrl = 12'h3;
   endtask

   task automatic drive_use(input logic [4:0] rs1, input logic [4:0] rs2);
      idle();
      id_valid = 1; id_regwrite = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = 5'd6;
      id_ctrl = 12'h5;
   endtask

   task automatic bump_bub();
      if (exp_bub != 64'((1 << BCW) - 1)) exp_bub = exp_bub + 1;
   endtask

   initial begin
      // reset held with random inputs
      rst = 0;
      idle();
      id_valid = 1'($urandom); id_pc = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_rd = 5'($urandom); id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
      id_regwrite = 1; id_memread = 1; id_ctrl = 12'($urandom); flush = 1'($urandom);
      mem_regwrite = 1; mem_rd = 5'($urandom); mem_result = $urandom;
      wb_regwrite = 1; wb_rd = 5'($urandom); wb_result = $urandom;
      tick();
      push("rst_valid", S_EXV, 0);  push("rst_pc", S_PC, 0);    push("rst_rs1", S_RS1, 0);
      push("rst_rd", S_RD, 0);      push("rst_imm", S_IMM, 0);  push("rst_rw", S_RW, 0);
      push("rst_mr", S_MR, 0);      push("rst_ctrl", S_CTRL, 0); push("rst_a", S_A, 0);
      push("rst_b", S_B, 0);        push("rst_fa", S_FA, 0);    push("rst_fb", S_FB, 0);
      push("rst_bub", S_BUB, 0);    push("rst_stall", S_STALL, 0);
      tick();

      // first capture after release
      rst = 1;
      idle();
      id_valid = 1; id_pc = 32'h10; id_rd1 = 32'h11; id_rd = 5'd5;
      push("cap_pc", S_PC, 64'h10); push("cap_a", S_A, 64'h11); push("cap_valid", S_EXV, 1);
      push("cap_rd", S_RD, 5);
      tick();

      // load-use: lw x5 then add x6,x5,x7
      drive_lw(5'd5);
      push("lw_mr", S_MR, 1);
      tick();
      drive_use(5'd5, 5'd7);
      push("lu_stall", S_STALL, 1);
      settle();
      bump_bub();
      push("lu_bubble_valid", S_EXV, 0); push("lu_bubble_rd", S_RD, 0);
      push("lu_bubble_ctrl", S_CTRL, 0); push("lu_bub1", S_BUB, exp_bub);
      tick();
      push("lu_nostall", S_STALL, 0);
      settle();
      push("lu_cap_rs1", S_RS1, 5); push("lu_cap_valid", S_EXV, 1); push("lu_cap_rd", S_RD, 6);
      tick();

      // forwarding priority on the a side
      idle();
      id_valid = 1; id_rs1 = 5'd3; id_rd1 = 32'h1234; id_imm = 32'hFFFF_FFF0;
      push("fw_imm", S_IMM, 64'hFFFF_FFF0);
      tick();
      id_valid = 0;
      mem_regwrite = 1; mem_rd = 5'd3; mem_result = 32'hAAAA;
      wb_regwrite = 1;  wb_rd = 5'd3;  wb_result = 32'hBBBB;
      push("fw_mem_sel", S_FA, 2); push("fw_mem_a", S_A, 64'hAAAA);
      settle();
      mem_regwrite = 0;
      push("fw_wb_sel", S_FA, 1); push("fw_wb_a", S_A, 64'hBBBB);
      settle();
      wb_regwrite = 0;
      push("fw_rf_sel", S_FA, 0); push("fw_rf_a", S_A, 64'h1234);
      settle();

      // x0 guard on the b side
      mem_regwrite = 1; mem_rd = 5'd0; mem_result = 32'hDEAD;
      push("x0_sel", S_FB, 0); push("x0_b", S_B, 0); push("x0_asel", S_FA, 0);
      settle();

      // b side MEM forward
      idle();
      id_valid = 1; id_rs2 = 5'd4; id_rd2 = 32'h55;
      tick();
      id_valid = 0;
      push("fb_rf_b", S_B, 64'h55);
      settle();
      mem_regwrite = 1; mem_rd = 5'd4; mem_result = 32'hDEAD;
      wb_regwrite = 1;  wb_rd = 5'd4;  wb_result = 32'hBEEF;
      push("fb_mem_sel", S_FB, 2); push("fb_mem_b", S_B, 64'hDEAD);
      settle();

      // flush and hazard together
      drive_lw(5'd5);
      tick();
      drive_use(5'd5, 5'd0);
      flush = 1;
      push("fl_stall", S_STALL, 0);
      settle();
      push("fl_valid", S_EXV, 0); push("fl_rw", S_RW, 0); push("fl_bub", S_BUB, exp_bub);
      tick();

      // saturation across 20 load-use events
      for (int i = 0; i < 20; i++) begin
         drive_lw(5'd5);
         tick();
         drive_use(5'd0, 5'd5);
         push("sat_stall", S_STALL, 1);
         settle();
         bump_bub();
         push("sat_valid", S_EXV, 0);
         tick();
      end
      push("sat_bub", S_BUB, 64'hF);
      settle();
      push("sat_model", S_BUB, exp_bub);
      settle();

      // reset asserted mid-stall
      drive_lw(5'd5);
      tick();
      drive_use(5'd5, 5'd7);
      push("ms_stall", S_STALL, 1);
      settle();
      #2;
      rst = 0;
      exp_bub = 0;
      push("ms_stall_drop", S_STALL, 0); push("ms_valid", S_EXV, 0);
      push("ms_bub", S_BUB, exp_bub);     push("ms_mr", S_MR, 0);
      settle();
      rst = 1;
      push("ms_cap_valid", S_EXV, 1); push("ms_cap_rs1", S_RS1, 5);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
